// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - Shared SPART definitions: serial FSM state encoding and frame constants.
package spart_pkg;

    // Line states shared by the transmit and (future) receive halves.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } spart_state_e;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic LINE_IDLE       = 1'b1;

endpackage

// File: rtl/spart_tx_fifo.sv
// rtl/spart_tx_fifo.sv - Byte FIFO buffering processor sends ahead of the serialiser.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   push, din     write request and byte; ignored while full
//   pop, dout     read request and head byte (dout valid whenever not empty)
//   count         occupancy 0..DEPTH
//   full, empty   full is registered; empty decodes the count register
module spart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          push_ok;
    logic          pop_ok;

    // full_q reflects the state before this edge's pop, so a push that
    // coincides with a pop at full is still refused.
    assign push_ok = push & ~full_q;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
        end
    end

    // Storage needs no reset: occupancy is governed by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/spart_tx.sv
// rtl/spart_tx.sv - SPART transmitter: FIFO-buffered 8N1 (or 8E1) serialiser.
// Optional feature macro: SPART_TX_PARITY_EN (adds an even-parity bit, 8E1).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   send, send_data     one-cycle push of a byte from the processor
//   full                FIFO holds DEPTH bytes (registered)
//   TxD                 serial output, idles high (registered)
//   tx_busy             frame in progress or bytes still queued
//   tx_count            FIFO occupancy
module spart_tx
    import spart_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DIVISOR = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     send,
    input  logic [7:0]               send_data,
    output logic                     full,
    output logic                     TxD,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   tx_count
);

    localparam int             BW        = $clog2(DIVISOR);
    localparam logic [BW-1:0]  BAUD_LOAD = BW'(DIVISOR - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(FRAME_DATA_BITS - 1);

    spart_state_e  state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          pop;
    logic          baud_done;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;

`ifdef SPART_TX_PARITY_EN
    logic          parity_q;
`endif

    spart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (send),
        .din   (send_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (tx_count),
        .full  (full),
        .empty (fifo_empty)
    );

    assign baud_done = (baud_q == '0);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = BAUD_LOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = BAUD_LOAD;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == LAST_BIT) begin
`ifdef SPART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`ifdef SPART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_done) begin
                    baud_d  = BAUD_LOAD;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`endif
            ST_STOP: begin
                // Baud counter is left at zero; the following IDLE cycle
                // is the single gap between back-to-back frames.
                if (baud_done) begin
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level is decoded from the current state and then registered,
    // so TxD trails the state by one cycle and cannot glitch.
    always_comb begin
        txd_d = LINE_IDLE;
        case (state_q)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_q[0];
`ifdef SPART_TX_PARITY_EN
            ST_PARITY: txd_d = parity_q;
`endif
            default:   txd_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= LINE_IDLE;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

`ifdef SPART_TX_PARITY_EN
    // Parity is captured with the byte because the shifter consumes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (pop) begin
            parity_q <= ^fifo_dout;
        end
    end
`endif

    assign TxD     = txd_q;
    assign tx_busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_spart_tx.sv
// tb/tb_spart_tx.sv - Directed self-checking bench for spart_tx.
module tb_spart_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef SPART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FP = NB * DIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       send = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       full;
    logic       TxD;
    logic       tx_busy;
    logic [2:0] tx_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       rx_pq[$];
    logic       rx_eq[$];

    logic       rx_act = 1'b0;
    logic       rx_prev = 1'b1;
    logic       rx_err = 1'b0;
    logic       rx_pb = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    int         rx_cnt = 0;
    int         rx_st = 0;
    int         rx_j = 0;

    spart_tx #(
        .DEPTH   (DEPTH),
        .DIVISOR (DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .send      (send),
        .send_data (send_data),
        .full      (full),
        .TxD       (TxD),
        .tx_busy   (tx_busy),
        .tx_count  (tx_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Line receiver: samples each bit in its middle, relative to the start edge.
    always @(negedge clk) begin
        if (!rst) begin
            rx_act  = 1'b0;
            rx_prev = 1'b1;
        end else begin
            if (!rx_act) begin
                if (rx_prev && !TxD) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                    rx_st  = cyc;
                    rx_err = 1'b0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_act && (rx_cnt % DIV) == DIV / 2) begin
                rx_j = rx_cnt / DIV;
                if (rx_j == 0) begin
                    rx_err = rx_err | TxD;
                end else if (rx_j <= 8) begin
                    rx_byte[rx_j-1] = TxD;
                end else if (rx_j == NB - 1) begin
                    rx_q.push_back(rx_byte);
                    rx_t.push_back(rx_st);
                    rx_pq.push_back(rx_pb);
                    rx_eq.push_back(rx_err | ~TxD);
                    rx_act = 1'b0;
                end else begin
                    rx_pb = TxD;
                end
            end
            rx_prev = TxD;
        end
    end

    logic [7:0] exp_bytes [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h77};
    int         exp_cnt   [5] = '{1, 1, 2, 3, 4};
    logic       bits [NB];
    logic [7:0] v;

    initial begin
        // Reset state
        step(3);
        chk("rst_txd", TxD, 1);
        chk("rst_full", full, 0);
        chk("rst_count", tx_count, 0);
        chk("rst_busy", tx_busy, 0);
        rst = 1'b1;
        step(2);

        // Single frame 0xA5, checked cycle by cycle
        v = 8'hA5;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = v[i];
`ifdef SPART_TX_PARITY_EN
        bits[9] = 1'b0;
`endif
        bits[NB-1] = 1'b1;
        send = 1'b1; send_data = v;
        step(1);
        send = 1'b0;
        chk("a5_count_push", tx_count, 1);
        chk("a5_busy", tx_busy, 1);
        step(1);
        chk("a5_txd_pop", TxD, 1);
        chk("a5_count_pop", tx_count, 0);
        step(1);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < DIV; c++) begin
                chk($sformatf("a5_bit%0d_c%0d", b, c), TxD, bits[b]);
                step(1);
            end
        end
        chk("a5_busy_end", tx_busy, 0);
        chk("a5_txd_end", TxD, 1);
        step(5);
        rx_q.delete(); rx_t.delete(); rx_pq.delete(); rx_eq.delete();

        // Burst of five pushes, a rejected push at full, push racing a pop
        for (int k = 0; k < 5; k++) begin
            send = 1'b1; send_data = 8'(k + 1);
            step(1);
            chk($sformatf("burst_count%0d", k), tx_count, exp_cnt[k]);
            if (k == 3) chk("burst_full_before5", full, 0);
        end
        send = 1'b0;
        chk("burst_full", full, 1);
        step(5);
        send = 1'b1; send_data = 8'hFF;
        step(1);
        send = 1'b0;
        chk("ff_count", tx_count, 4);
        chk("ff_full", full, 1);
        step(FP - 10);
        chk("pre_pop_count", tx_count, 4);
        send = 1'b1; send_data = 8'h77;
        step(1);
        chk("race_count", tx_count, 3);
        chk("race_full", full, 0);
        step(1);
        send = 1'b0;
        chk("retry_count", tx_count, 4);
        chk("retry_full", full, 1);
        for (int i = 0; i < 1000 && rx_q.size() < 6; i++) step(1);
        chk("frames_n", rx_q.size(), 6);
        for (int k = 0; k < 6 && k < rx_q.size(); k++) begin
            chk($sformatf("frame%0d_byte", k), rx_q[k], exp_bytes[k]);
            chk($sformatf("frame%0d_framing", k), rx_eq[k], 0);
`ifdef SPART_TX_PARITY_EN
            chk($sformatf("frame%0d_parity", k), rx_pq[k], ^exp_bytes[k]);
`endif
            if (k > 0) chk($sformatf("frame%0d_gap", k), rx_t[k] - rx_t[k-1], FP);
        end
        step(10);
        chk("burst_idle", tx_busy, 0);

`ifdef SPART_TX_PARITY_EN
        rx_q.delete(); rx_t.delete(); rx_pq.delete(); rx_eq.delete();
        send = 1'b1; send_data = 8'h07;
        step(1);
        send = 1'b0;
        for (int i = 0; i < 200 && rx_q.size() < 1; i++) step(1);
        chk("p07_n", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            chk("p07_byte", rx_q[0], 8'h07);
            chk("p07_parity", rx_pq[0], 1);
        end
        step(10);
`endif

        // Reset in the middle of a frame with a byte still queued
        rx_q.delete(); rx_t.delete(); rx_pq.delete(); rx_eq.delete();
        send = 1'b1; send_data = 8'h3C;
        step(1);
        send_data = 8'h11;
        step(1);
        send = 1'b0;
        step(9);
        chk("mid_txd_low", TxD, 0);
        #2 rst = 1'b0;
        #1;
        chk("mrst_txd", TxD, 1);
        chk("mrst_full", full, 0);
        chk("mrst_count", tx_count, 0);
        chk("mrst_busy", tx_busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mrst_hold_txd", TxD, 1);
        chk("mrst_hold_count", tx_count, 0);
        rst = 1'b1;
        step(60);
        chk("post_rst_frames", rx_q.size(), 0);
        chk("post_rst_busy", tx_busy, 0);
        chk("post_rst_txd", TxD, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
